// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout, plus branch and hazard control.
// Optional saturating stall counters are enabled by defining PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             freeze_id_exe,
  output logic             freeze_exe_mem,
  output logic             flush_if_id,
  output logic             bubble_id_exe,
  output logic             bubble_mem_wb,
  output logic [1:0]       state,
  output logic [7:0]       wait_cnt,
  output logic             mem_err
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] hazard_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b11
  } state_e;

  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_e state_q, state_d;
  logic   mem_freeze;
  logic   hazard_stall;
  logic   timeout;

  assign state      = state_q;
  assign mem_freeze = ((state_q == MEM_WAIT) || (state_q == RUN && mem_access)) && !mem_ready;
  assign timeout    = (state_q == MEM_WAIT) && !mem_ready && (wait_cnt == LAST_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // NOTE: default assignment first keeps this block purely combinational (no latches).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (mem_access && !mem_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready)                state_d = RUN;
                else if (timeout)             state_d = ERROR;
      ERROR:    state_d = ERROR;
      default:  state_d = RUN;
    endcase
  end

  // Priority: memory freeze/error, then branch flush, then hazard stall.
  always_comb begin
    freeze_pc      = 1'b0;
    freeze_if_id   = 1'b0;
    freeze_id_exe  = 1'b0;
    freeze_exe_mem = 1'b0;
    flush_if_id    = 1'b0;
    bubble_id_exe  = 1'b0;
    bubble_mem_wb  = 1'b0;
    hazard_stall   = 1'b0;
    if (mem_freeze || state_q == ERROR) begin
      freeze_pc      = 1'b1;
      freeze_if_id   = 1'b1;
      freeze_id_exe  = 1'b1;
      freeze_exe_mem = 1'b1;
      bubble_mem_wb  = 1'b1;
    end else if (branch_taken) begin
      flush_if_id    = 1'b1;
      bubble_id_exe  = 1'b1;
    end else if (hazard_detected) begin
      freeze_pc      = 1'b1;
      freeze_if_id   = 1'b1;
      bubble_id_exe  = 1'b1;
      hazard_stall   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      if (state_q == RUN)                       wait_cnt <= 8'd0;
      else if (state_q == MEM_WAIT && !mem_ready) wait_cnt <= wait_cnt + 8'd1;
      if (timeout) mem_err <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hazard_stall_cnt <= '0;
      mem_stall_cnt    <= '0;
    end else begin
      if (hazard_stall && hazard_stall_cnt != '1) hazard_stall_cnt <= hazard_stall_cnt + 1'b1;
      if (mem_freeze && mem_stall_cnt != '1)      mem_stall_cnt    <= mem_stall_cnt + 1'b1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = hazard_stall ^ (^CNT_W);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MEM_TIMEOUT=4); counter checks run when
// PIPE_CTRL_PERF_CNT_EN is defined.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, hazard_detected, branch_taken, mem_access, mem_ready;
  logic        freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem;
  logic        flush_if_id, bubble_id_exe, bubble_mem_wb;
  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic        mem_err;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [15:0] hazard_stall_cnt, mem_stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem, flush_if_id, bubble_id_exe, bubble_mem_wb}
  logic [6:0] ctl;
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] FRZ  = 7'b1111001;
  localparam logic [6:0] BR   = 7'b0000110;
  localparam logic [6:0] HZ   = 7'b1100010;

  assign ctl = {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
                flush_if_id, bubble_id_exe, bubble_mem_wb};

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .mem_access      (mem_access),
    .mem_ready       (mem_ready),
    .freeze_pc       (freeze_pc),
    .freeze_if_id    (freeze_if_id),
    .freeze_id_exe   (freeze_id_exe),
    .freeze_exe_mem  (freeze_exe_mem),
    .flush_if_id     (flush_if_id),
    .bubble_id_exe   (bubble_id_exe),
    .bubble_mem_wb   (bubble_mem_wb),
    .state           (state),
    .wait_cnt        (wait_cnt),
    .mem_err         (mem_err)
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    .hazard_stall_cnt(hazard_stall_cnt),
    .mem_stall_cnt   (mem_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic h, input logic b, input logic a, input logic r);
    hazard_detected = h;
    branch_taken    = b;
    mem_access      = a;
    mem_ready       = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_state", state, 2'b00);
    check("reset_wait_cnt", wait_cnt, 8'd0);
    check("reset_mem_err", mem_err, 1'b0);
    check("reset_ctl", ctl, NONE);

`ifdef PIPE_CTRL_PERF_CNT_EN
    check("reset_hz_cnt", hazard_stall_cnt, 16'd0);
    check("reset_mem_cnt", mem_stall_cnt, 16'd0);
    drive(1, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 1, 0);
    tick();
    tick();
    tick();
    drive(0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0);
    check("perf_hz_cnt", hazard_stall_cnt, 16'd2);
    check("perf_mem_cnt", mem_stall_cnt, 16'd3);
    drive(1, 0, 0, 0);
    repeat (65540) tick();
    check("perf_hz_sat", hazard_stall_cnt, 16'hFFFF);
    drive(0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("perf_rst_cnt", hazard_stall_cnt, 16'd0);
`endif

    // Zero-wait access: no freeze, no state change
    drive(0, 0, 1, 1);
    check("zero_wait_ctl", ctl, NONE);
    tick();
    check("zero_wait_state", state, 2'b00);
    check("zero_wait_cnt", wait_cnt, 8'd0);

    // Stray mem_ready in RUN ignored
    drive(0, 0, 0, 1);
    check("stray_ready_ctl", ctl, NONE);
    tick();
    check("stray_ready_state", state, 2'b00);

    // Branch beats hazard; hazard alone stalls front end
    drive(1, 1, 0, 0);
    check("br_hz_ctl", ctl, BR);
    drive(1, 0, 0, 0);
    check("hz_ctl", ctl, HZ);
    drive(0, 1, 0, 0);
    check("br_ctl", ctl, BR);
    tick();
    check("hz_br_state", state, 2'b00);

    // Three-cycle memory wait
    drive(0, 0, 1, 0);
    check("mw_c0_ctl", ctl, FRZ);
    tick();
    check("mw_c1_state", state, 2'b01);
    check("mw_c1_cnt", wait_cnt, 8'd0);
    check("mw_c1_ctl", ctl, FRZ);
    tick();
    check("mw_c2_cnt", wait_cnt, 8'd1);
    check("mw_c2_ctl", ctl, FRZ);
    tick();
    check("mw_c3_cnt", wait_cnt, 8'd2);
    drive(1, 0, 1, 1);
    check("mw_ready_ctl", ctl, HZ);
    tick();
    check("mw_done_state", state, 2'b00);
    drive(0, 0, 0, 0);
    tick();
    check("mw_cnt_clear", wait_cnt, 8'd0);

    // Branch held during a 2-cycle wait: flush only in the ready cycle
    drive(0, 1, 1, 0);
    check("brw_c0_ctl", ctl, FRZ);
    tick();
    check("brw_c1_ctl", ctl, FRZ);
    tick();
    drive(0, 1, 1, 1);
    check("brw_ready_ctl", ctl, BR);
    tick();
    check("brw_state", state, 2'b00);
    drive(0, 0, 0, 0);
    tick();

    // Timeout into ERROR
    drive(0, 0, 1, 0);
    repeat (4) tick();
    check("to_pre_state", state, 2'b01);
    check("to_pre_cnt", wait_cnt, 8'd3);
    check("to_pre_err", mem_err, 1'b0);
    tick();
    check("to_state", state, 2'b11);
    check("to_err", mem_err, 1'b1);
    drive(0, 1, 0, 1);
    check("err_ctl", ctl, FRZ);
    tick();
    check("err_hold_state", state, 2'b11);
    check("err_hold_err", mem_err, 1'b1);

    // Reset leaves ERROR
    rst = 1'b1;
    drive(1, 1, 1, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    check("rst_err_state", state, 2'b00);
    check("rst_err_err", mem_err, 1'b0);
    check("rst_err_cnt", wait_cnt, 8'd0);
    check("rst_err_ctl", ctl, NONE);

    // mem_ready on the timeout cycle wins
    drive(0, 0, 1, 0);
    repeat (4) tick();
    check("race_cnt", wait_cnt, 8'd3);
    drive(0, 0, 1, 1);
    check("race_ctl", ctl, NONE);
    tick();
    check("race_state", state, 2'b00);
    check("race_err", mem_err, 1'b0);

    // Reset during MEM_WAIT
    drive(0, 0, 1, 0);
    tick();
    check("rst_mw_pre", state, 2'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mw_state", state, 2'b00);
    drive(0, 0, 0, 0);
    check("rst_mw_ctl_idle", ctl, NONE);
    drive(0, 0, 1, 0);
    check("rst_mw_ctl_acc", ctl, FRZ);
    drive(0, 0, 0, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
